// File: rtl/iarraysp_arb_pkg.sv
// Shared constants, pointer-width helper and read-tag type for iarraysp_arb.
package iarraysp_arb_pkg;

  localparam int RDLAT_DEF = 2;
  localparam int NREQ_MAX  = 8;

  function automatic int ptrw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                vld;
    logic [NREQ_MAX-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Round-robin pick: first set bit of vec at or above ptr, wrapping modulo NREQ.
// Latency: combinational. Backpressure: none; idx falls back to ptr when vec is empty.
module arb_rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] vec,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   idx,
  output logic            any
);

  int k;

  always_comb begin
    win = '0;
    idx = ptr;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!any && vec[k]) begin
        any    = 1'b1;
        win[k] = 1'b1;
        idx    = PW'(k);
      end
    end
  end

endmodule

// File: rtl/iarraysp_arb.sv
// Round-robin arbiter sharing one single-port registered RAM; read data returns RDLAT cycles after grant.
// Backpressure: requesters hold req until gnt. Define IARRAYSP_ARB_WRPRI_EN to give writers strict priority.
module iarraysp_arb
  import iarraysp_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ADDRBIT = 11,
  parameter int WIDTH   = 32,
  parameter int RDLAT   = RDLAT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         rwe,
  input  logic [NREQ*ADDRBIT-1:0] radr,
  input  logic [NREQ*WIDTH-1:0]   rdi,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rvld,
  output logic [WIDTH-1:0]        rdo,
  output logic [ADDRBIT-1:0]      ram_a,
  output logic                    ram_we,
  output logic                    ram_re,
  output logic [WIDTH-1:0]        ram_di,
  input  logic [WIDTH-1:0]        ram_do
);

  localparam int PW = ptrw(NREQ);

  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] win;
  logic [PW-1:0]   idx;
  logic            any;
  logic            granted;
  rd_tag_t         tag_q [RDLAT];
  logic [NREQ_MAX-1:0] unused_tag_id;

`ifdef IARRAYSP_ARB_WRPRI_EN
  logic [NREQ-1:0] wr_win, rd_win;
  logic [PW-1:0]   wr_idx, rd_idx;
  logic            wr_any, rd_any;

  arb_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick_wr (
    .vec(req & rwe), .ptr(ptr), .win(wr_win), .idx(wr_idx), .any(wr_any)
  );
  arb_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick_rd (
    .vec(req & ~rwe), .ptr(ptr), .win(rd_win), .idx(rd_idx), .any(rd_any)
  );

  // Any pending writer shuts readers out entirely for that cycle.
  assign win = wr_any ? wr_win : rd_win;
  assign idx = wr_any ? wr_idx : rd_idx;
  assign any = wr_any | rd_any;
`else
  arb_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .vec(req), .ptr(ptr), .win(win), .idx(idx), .any(any)
  );
`endif

  assign granted = any & rst_;
  assign gnt     = win & {NREQ{rst_}};
  assign ram_a   = radr[idx*ADDRBIT +: ADDRBIT];
  assign ram_di  = rdi[idx*WIDTH +: WIDTH];
  assign ram_we  = granted & rwe[idx];
  assign ram_re  = granted & ~rwe[idx];

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ptr <= '0;
    end else if (granted) begin
      ptr <= (int'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
    end
  end

  // Tag pipeline mirrors the RAM read path so rvld lines up with ram_do.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < RDLAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0].vld <= ram_re;
      tag_q[0].id  <= NREQ_MAX'(gnt);
      for (int i = 1; i < RDLAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign unused_tag_id = tag_q[RDLAT-1].id;
  assign rvld = tag_q[RDLAT-1].vld ? tag_q[RDLAT-1].id[NREQ-1:0] : '0;
  assign rdo  = ram_do;

endmodule

// File: tb/tb_iarraysp_arb.sv
// Directed bench for iarraysp_arb (NREQ=4 plus an NREQ=3 wrap instance) with a two-stage RAM model.
module tb_iarraysp_arb;

  localparam int AW = 11;
  localparam int W  = 32;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]      req, rwe, gnt, rvld;
  logic [4*AW-1:0] radr;
  logic [4*W-1:0]  rdi;
  logic [W-1:0]    rdo, ram_di, ram_do;
  logic [AW-1:0]   ram_a;
  logic            ram_we, ram_re;

  logic [2:0]      req3, gnt3, rvld3;
  logic [W-1:0]    rdo3, ram_di3;
  logic [AW-1:0]   ram_a3;
  logic            ram_we3, ram_re3;

  iarraysp_arb #(.NREQ(4), .ADDRBIT(AW), .WIDTH(W), .RDLAT(2)) dut (
    .clk(clk), .rst_(rst_), .req(req), .rwe(rwe), .radr(radr), .rdi(rdi),
    .gnt(gnt), .rvld(rvld), .rdo(rdo), .ram_a(ram_a), .ram_we(ram_we),
    .ram_re(ram_re), .ram_di(ram_di), .ram_do(ram_do)
  );

  iarraysp_arb #(.NREQ(3), .ADDRBIT(AW), .WIDTH(W), .RDLAT(2)) dut3 (
    .clk(clk), .rst_(rst_), .req(req3), .rwe(3'b000), .radr({3*AW{1'b0}}),
    .rdi({3*W{1'b0}}), .gnt(gnt3), .rvld(rvld3), .rdo(rdo3), .ram_a(ram_a3),
    .ram_we(ram_we3), .ram_re(ram_re3), .ram_di(ram_di3), .ram_do({W{1'b0}})
  );

  // RAM array plus wrapper output register: data appears two cycles after re.
  logic [W-1:0] mem [2**AW];
  logic [W-1:0] q1;
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_di;
    if (ram_re) q1 <= mem[ram_a];
    ram_do <= q1;
  end

  int ncmp = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

`ifdef IARRAYSP_ARB_WRPRI_EN
  localparam logic [3:0] PRI_FIRST  = 4'b1000;
  localparam logic [3:0] PRI_SECOND = 4'b0001;
  localparam bit         WRPRI      = 1'b1;
`else
  localparam logic [3:0] PRI_FIRST  = 4'b0001;
  localparam logic [3:0] PRI_SECOND = 4'b1000;
  localparam bit         WRPRI      = 1'b0;
`endif

  initial begin
    req  = 4'b1111;
    rwe  = 4'b0000;
    radr = '0;
    rdi  = '0;
    req3 = 3'b101;

    // Reset held with all requesting
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_re", ram_re, 0);
    chk("rst_rvld", rvld, 0);
    chk("rst_gnt3", gnt3, 0);
    @(posedge clk); #1 rst_ = 1'b1;

    // Fairness on all-read traffic, NREQ=3 wrap alongside
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_gnt", gnt, 1 << (i % 4));
      chk("rr_re", ram_re, 1);
      if (i >= 2) chk("rr_rvld", rvld, 1 << ((i - 2) % 4));
      else        chk("rr_rvld_early", rvld, 0);
      chk("wrap_gnt3", gnt3, (i % 2 == 0) ? 1 : 4);
      chk("wrap_ptr3_lt3", {31'b0, dut3.ptr < 2'd3}, 1);
      @(posedge clk); #1;
    end
    req  = 4'b0000;
    req3 = 3'b000;
    repeat (3) @(posedge clk);
    #1;

    // Write 0xDEADBEEF to 0x005 via requester 1
    rwe = 4'b0010;
    radr[1*AW +: AW] = 11'h005;
    rdi[1*W +: W]    = 32'hDEADBEEF;
    req = 4'b0010;
    @(negedge clk);
    chk("wr_gnt", gnt, 4'b0010);
    chk("wr_we", ram_we, 1);
    chk("wr_re", ram_re, 0);
    chk("wr_a", ram_a, 11'h005);
    chk("wr_di", ram_di, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Requester 2 reads it back
    req = 4'b0100;
    rwe = 4'b0000;
    radr[2*AW +: AW] = 11'h005;
    @(negedge clk);
    chk("rd_gnt", gnt, 4'b0100);
    chk("rd_re", ram_re, 1);
    chk("rd_a", ram_a, 11'h005);
    @(posedge clk); #1 req = 4'b0000;
    @(negedge clk);
    chk("rd_rvld_t1", rvld, 0);
    @(negedge clk);
    chk("rd_rvld_t2", rvld, 4'b0100);
    chk("rd_rdo_t2", rdo, 32'hDEADBEEF);
    @(negedge clk);
    chk("rd_rvld_t3", rvld, 0);

    // Reset while a read is in flight
    @(posedge clk); #1 req = 4'b0001;
    @(negedge clk);
    chk("mid_gnt", gnt, 4'b0001);
    chk("mid_re", ram_re, 1);
    @(posedge clk); #1;
    req  = 4'b0000;
    rst_ = 1'b0;
    @(negedge clk);
    chk("mid_rst_rvld", rvld, 0);
    @(posedge clk); #1 rst_ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_after_rvld", rvld, 0);
    end

    // Write vs read contention with ptr back at 0
    @(posedge clk); #1;
    req = 4'b1001;
    rwe = 4'b1000;
    @(negedge clk);
    chk("pri_first", gnt, PRI_FIRST);
    chk("pri_first_we", ram_we, WRPRI);
    @(posedge clk); #1 req = req & ~PRI_FIRST;
    @(negedge clk);
    chk("pri_second", gnt, PRI_SECOND);
    @(posedge clk); #1 req = 4'b1001;

    // Continuous writer: readers starve only with write priority
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("starve_gnt", gnt, WRPRI ? 4'b1000 : ((i % 2 == 0) ? 4'b0001 : 4'b1000));
      @(posedge clk); #1;
    end
    req = 4'b0000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/iarraysp_arb.md
Name: iarraysp_arb

Overview:
- Round-robin arbiter that shares one single-port wrapped RAM (registered-output, single-port array) between NREQ requesters.
- Drives the RAM address, write-enable, read-enable and write-data ports from the winning requester.
- Tracks in-flight reads and returns read data with a per-requester valid strobe at the fixed RAM read latency.
- Sits between client engines (e.g. RS/ECC table lookups) and one shared table memory.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ADDRBIT, 11, RAM address width
- WIDTH, 32, RAM data width
- RDLAT, 2, grant-to-data latency: 1 for the RAM array plus 1 for the wrapper output register

Ports:
- clk  in  1  system clock
- rst_  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester access request, held until granted
- rwe  in  NREQ  per-requester access type: 1 write, 0 read
- radr  in  NREQ*ADDRBIT  packed addresses; requester n at [n*ADDRBIT +: ADDRBIT]
- rdi  in  NREQ*WIDTH  packed write data
- gnt  out  NREQ  one-hot grant; access accepted this cycle
- rvld  out  NREQ  one-hot read-data-valid
- rdo  out  WIDTH  read data, broadcast to all requesters, qualified by rvld
- ram_a  out  ADDRBIT  to RAM a
- ram_we  out  1  to RAM we
- ram_re  out  1  to RAM re
- ram_di  out  WIDTH  to RAM di
- ram_do  in  WIDTH  from RAM do (already registered in the wrapper)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_.
- Reset values: round-robin pointer = 0; read tag pipeline cleared; rvld = 0. While rst_ is low, gnt, ram_we and ram_re are forced to 0.
- Grant generation:
  - gnt is combinational from req and the pointer.
  - Winner is the first requester with req=1, searching from ptr upward modulo NREQ.
  - At most one grant per cycle; one access per cycle, no bubbles.
  - A transfer occurs when req[n] & gnt[n].
  - Requesters must hold req, rwe, radr and rdi stable until granted.
- RAM drive (combinational mux of the winner):
  - ram_a = winner radr.
  - ram_we = granted & rwe[w].
  - ram_re = granted & ~rwe[w].
  - ram_di = winner rdi.
  - With no grant: ram_we = ram_re = 0; ram_a and ram_di hold the mux value of requester ptr (don't care).
- Pointer: on any grant, ptr <= (w+1) mod NREQ. With no grant, ptr holds.
- Read return:
  - A shift register of RDLAT stages carries {valid, one-hot id}.
  - A read granted in cycle T asserts rvld[id] in cycle T+RDLAT, with rdo = ram_do in that cycle.
  - Writes produce no rvld.
  - Back-to-back reads return in grant order, one per cycle.
- Hazards:
  - A read to an address written in the previous cycle returns the new data. This is RAM behaviour and needs no arbiter forwarding.
  - A write followed by a read in the same cycle is impossible (one grant per cycle).
- Reset mid-operation: in-flight reads are discarded (no rvld after reset). The pointer returns to 0.
- Width rules:
  - ptr is $clog2(NREQ) bits.
  - Modulo wrap for NREQ not a power of two: when ptr would equal NREQ, it becomes 0.
  - ptr never holds a value >= NREQ.

Optional Feature:
- Macro: IARRAYSP_ARB_WRPRI_EN.
- Defined:
  - Two-level arbitration. If any requester with rwe=1 is requesting, the grant goes to a write requester only (round-robin among writers from ptr).
  - Otherwise round-robin among readers.
  - The single shared ptr is updated as above.
  - Bench must show reads starve while writes are continuous; this is accepted.
- Undefined: plain round-robin regardless of rwe.

Decomposition:
- Shared package iarraysp_arb_pkg:
  - RDLAT default.
  - PTRW function ($clog2 wrapper).
  - Read-tag typedef {vld, id[NREQ-1:0]}.
- One sub-module: arb_rr_pick.
  - Combinational: inputs NREQ-bit vector and ptr; outputs one-hot winner and encoded index.
  - Instantiated once without the macro, twice (writers and readers) with IARRAYSP_ARB_WRPRI_EN.
- Top holds the pointer, the tag pipeline and the RAM muxes.

Test Plan:
- Reset: hold rst_=0 with req=4'b1111 -> gnt=0, ram_we=ram_re=0, rvld=0. Release -> first gnt=4'b0001.
- Fairness: req=4'b1111 held, all reads, for 8 cycles -> gnt sequence 0001, 0010, 0100, 1000, 0001...; ram_re=1 every cycle.
- Read latency: pre-write addr 0x005=0xDEADBEEF via req1. Req2 reads 0x005, granted cycle T -> rvld=4'b0100 at T+2 with rdo=0xDEADBEEF; rvld=0 at T+1.
- Wrap with NREQ=3: req=3'b101 continuous -> gnt alternates 001, 100; ptr never reaches 3.
- Reset mid-read: grant a read at T, pull rst_ low at T+1, release -> no rvld ever for that read.
- With IARRAYSP_ARB_WRPRI_EN: req0 read and req3 write both pending, ptr=0 -> gnt=4'b1000 first, then 4'b0001. Without the macro -> 4'b0001 first.
